// File: rtl/gmii_pkg.sv
// Shared constants, mode encodings, FSM state type and PRBS8 step function
// for the GMII frame generator.
package gmii_pkg;
    localparam logic [7:0] GMII_PREAMBLE = 8'h55;
    localparam logic [7:0] GMII_SFD      = 8'hD5;
    localparam logic [7:0] GMII_IDLE     = 8'h00;
    localparam logic [7:0] PRBS_SEED     = 8'hFF;

    localparam logic [1:0] MODE_INC   = 2'b00;
    localparam logic [1:0] MODE_PRBS  = 2'b01;
    localparam logic [1:0] MODE_FIXED = 2'b10;

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, IPG} gen_state_t;

    // x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3 shifted into the LSB.
    function automatic logic [7:0] prbs8_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction
endpackage

// File: rtl/prbs8_lfsr.sv
// PRBS8 generator; q holds the byte to emit, seed_load wins over advance.
module prbs8_lfsr (
    input  logic       clk,
    input  logic       mr_main_reset,
    input  logic       seed_load,
    input  logic       advance,
    output logic [7:0] q
);
    import gmii_pkg::*;

    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge mr_main_reset) begin
        if (!mr_main_reset)
            r_lfsr <= PRBS_SEED;
        else if (seed_load)
            r_lfsr <= PRBS_SEED;
        else if (advance)
            r_lfsr <= prbs8_step(r_lfsr);
    end

    assign q = r_lfsr;
endmodule

// File: rtl/gmii_frame_gen.sv
// GMII transmit stimulus generator: preamble, SFD, patterned payload and IPG,
// with programmable frame count, lengths and TX_ER injection.
module gmii_frame_gen #(
    parameter int LEN_W        = 11,
    parameter int CNT_W        = 16,
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_MIN      = 12
) (
    input  logic             clk,
    input  logic             mr_main_reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] frame_count,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [7:0]       ipg_len,
    input  logic [1:0]       mode,
    input  logic [7:0]       fixed_byte,
    input  logic             err_en,
    input  logic [LEN_W-1:0] err_pos,
    output logic [7:0]       TXD,
    output logic             TX_EN,
    output logic             TX_ER,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);
    import gmii_pkg::*;

    localparam int CW = (LEN_W > 8) ? LEN_W : 8;

    gen_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_len;
    logic [CW-1:0]    r_ipg;
    logic [CNT_W-1:0] r_fc;
    logic [CNT_W-1:0] r_frames;
    logic [1:0]       r_mode;
    logic [7:0]       r_fixed;
    logic             r_err_en;
    logic [LEN_W-1:0] r_err_pos;
    logic             r_stop_seen;
    logic [7:0]       r_txd;
    logic             r_tx_en, r_tx_er, r_busy, r_done;

    gen_state_t       w_nstate;
    logic [CW-1:0]    w_ncnt;
    logic             w_start_ok, w_pay_end, w_fc_hit;
    logic [7:0]       w_prbs, w_txd;
    logic             w_tx_en, w_tx_er;

    assign w_fc_hit = (r_fc != '0) && (r_frames == r_fc);

    // r_state/r_cnt describe the byte currently on the wire; the outputs are
    // registered from the next state so they change on the same edge.
    always_comb begin
        w_nstate   = r_state;
        w_ncnt     = r_cnt + 1'b1;
        w_start_ok = 1'b0;
        w_pay_end  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ncnt = '0;
                if (start) begin
                    w_nstate   = PREAMBLE;
                    w_start_ok = 1'b1;
                end
            end
            PREAMBLE: if (r_cnt == CW'(PREAMBLE_LEN - 1)) begin
                w_nstate = SFD;
                w_ncnt   = '0;
            end
            SFD: begin
                w_nstate = PAYLOAD;
                w_ncnt   = '0;
            end
            PAYLOAD: if (r_cnt == r_len - 1'b1) begin
                w_nstate  = IPG;
                w_ncnt    = '0;
                w_pay_end = 1'b1;
            end
            IPG: if (r_cnt == r_ipg - 1'b1) begin
                w_ncnt   = '0;
                w_nstate = (r_stop_seen || stop || w_fc_hit) ? IDLE : PREAMBLE;
            end
            default: begin
                w_nstate = IDLE;
                w_ncnt   = '0;
            end
        endcase
    end

    always_comb begin
        w_txd = GMII_IDLE;
        case (w_nstate)
            PREAMBLE: w_txd = GMII_PREAMBLE;
            SFD:      w_txd = GMII_SFD;
            PAYLOAD: begin
                case (r_mode)
                    MODE_PRBS:  w_txd = w_prbs;
                    MODE_FIXED: w_txd = r_fixed;
                    default:    w_txd = w_ncnt[7:0];
                endcase
            end
            default:  w_txd = GMII_IDLE;
        endcase
        w_tx_en = (w_nstate == PREAMBLE) || (w_nstate == SFD) || (w_nstate == PAYLOAD);
        w_tx_er = (w_nstate == PAYLOAD) && r_err_en && (w_ncnt == CW'(r_err_pos));
    end

    // LFSR output is the byte for the payload index being registered next.
    prbs8_lfsr u_prbs (
        .clk          (clk),
        .mr_main_reset(mr_main_reset),
        .seed_load    (w_start_ok || (w_nstate == SFD)),
        .advance      (w_nstate == PAYLOAD),
        .q            (w_prbs)
    );

    always_ff @(posedge clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_len       <= CW'(1);
            r_ipg       <= CW'(IPG_MIN);
            r_fc        <= '0;
            r_frames    <= '0;
            r_mode      <= MODE_INC;
            r_fixed     <= '0;
            r_err_en    <= 1'b0;
            r_err_pos   <= '0;
            r_stop_seen <= 1'b0;
            r_txd       <= GMII_IDLE;
            r_tx_en     <= 1'b0;
            r_tx_er     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_txd   <= w_txd;
            r_tx_en <= w_tx_en;
            r_tx_er <= w_tx_er;
            r_busy  <= (w_nstate != IDLE);
            r_done  <= (r_state == IPG) && (w_nstate == IDLE);
            if (w_start_ok) begin
                r_len       <= (payload_len == '0) ? CW'(1) : CW'(payload_len);
                r_ipg       <= (ipg_len < 8'(IPG_MIN)) ? CW'(IPG_MIN) : CW'(ipg_len);
                r_fc        <= frame_count;
                r_mode      <= mode;
                r_fixed     <= fixed_byte;
                r_err_en    <= err_en;
                r_err_pos   <= err_pos;
                r_frames    <= '0;
                r_stop_seen <= stop;
            end else begin
                if (w_pay_end && (r_frames != '1))
                    r_frames <= r_frames + 1'b1;
                // stop is remembered per frame, so a new frame starts clean
                if ((r_state == IPG) && (w_nstate == PREAMBLE))
                    r_stop_seen <= 1'b0;
                else
                    r_stop_seen <= r_stop_seen | stop;
            end
        end
    end

    assign TXD         = r_txd;
    assign TX_EN       = r_tx_en;
    assign TX_ER       = r_tx_er;
    assign busy        = r_busy;
    assign done        = r_done;
    assign frames_sent = r_frames;
endmodule

// File: tb/tb_gmii_frame_gen.sv
// Randomized bench for gmii_frame_gen: a frame-level model predicts every
// wire cycle from the configuration and is compared cycle by cycle.
module tb_gmii_frame_gen;
    localparam int LEN_W = 11;
    localparam int CNT_W = 16;
    localparam int PRE   = 7;
    localparam int IPGM  = 12;

    logic             clk = 1'b0;
    logic             mr_main_reset = 1'b0;
    logic             start = 1'b0, stop = 1'b0;
    logic [CNT_W-1:0] frame_count = '0;
    logic [LEN_W-1:0] payload_len = '0;
    logic [7:0]       ipg_len = '0;
    logic [1:0]       mode = '0;
    logic [7:0]       fixed_byte = '0;
    logic             err_en = 1'b0;
    logic [LEN_W-1:0] err_pos = '0;
    logic [7:0]       TXD;
    logic             TX_EN, TX_ER, busy, done;
    logic [CNT_W-1:0] frames_sent;

    int n_tot = 0;
    int n_bad = 0;
    logic [7:0] prbs_ref [0:2047];

    gmii_frame_gen dut (
        .clk(clk), .mr_main_reset(mr_main_reset), .start(start), .stop(stop),
        .frame_count(frame_count), .payload_len(payload_len), .ipg_len(ipg_len),
        .mode(mode), .fixed_byte(fixed_byte), .err_en(err_en), .err_pos(err_pos),
        .TXD(TXD), .TX_EN(TX_EN), .TX_ER(TX_ER), .busy(busy), .done(done),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {4'h0, TXD, TX_EN, TX_ER, busy, done, frames_sent};
    endfunction

    // Expected wire state j cycles after the start edge (j=0 is the first 0x55).
    function automatic logic [31:0] expv(input int j, input int nfr, input int le,
                                         input int ge, input int md, input int fb,
                                         input int ee, input int ep);
        int F;
        int f;
        int off;
        int fs;
        int i;
        logic [7:0] d;
        logic en, er, bz, dn;
        F = PRE + 1 + le + ge;
        f = j / F;
        off = j % F;
        d = 8'h00; en = 1'b0; er = 1'b0; bz = 1'b1; dn = 1'b0;
        if (f >= nfr) begin
            bz = 1'b0;
            dn = (j == nfr * F);
            fs = nfr;
        end else begin
            fs = f + ((off >= PRE + 1 + le) ? 1 : 0);
            if (off < PRE) begin
                d = 8'h55; en = 1'b1;
            end else if (off == PRE) begin
                d = 8'hD5; en = 1'b1;
            end else if (off < PRE + 1 + le) begin
                i = off - PRE - 1;
                en = 1'b1;
                er = (ee != 0) && (i == ep);
                case (md)
                    1: d = prbs_ref[i];
                    2: d = fb[7:0];
                    default: d = i[7:0];
                endcase
            end
        end
        return {4'h0, d, en, er, bz, dn, fs[15:0]};
    endfunction

    // stop_fr <0: no stop; 0: stop only alongside start; >0: stop raised in
    // that frame's (0-based) preamble and held. Config inputs are scrambled
    // while busy and stray start pulses are thrown in.
    task automatic run(input string nm, input int fc, input int pl, input int ig,
                       input int md, input int fb, input int ee, input int ep,
                       input int stop_fr);
        int le;
        int ge;
        int F;
        int nfr;
        le  = (pl == 0) ? 1 : pl;
        ge  = (ig < IPGM) ? IPGM : ig;
        F   = PRE + 1 + le + ge;
        nfr = (stop_fr >= 0) ? stop_fr + 1 : fc;
        @(negedge clk);
        frame_count = CNT_W'(fc);
        payload_len = LEN_W'(pl);
        ipg_len     = 8'(ig);
        mode        = 2'(md);
        fixed_byte  = 8'(fb);
        err_en      = (ee != 0);
        err_pos     = LEN_W'(ep);
        start       = 1'b1;
        stop        = (stop_fr == 0);
        for (int j = 0; j <= nfr * F + 1; j++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d", nm, j), obs(), expv(j, nfr, le, ge, md, fb, ee, ep));
            start       = (j < nfr * F - 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            stop        = (stop_fr > 0) && (j >= stop_fr * F + 2);
            frame_count = CNT_W'($urandom);
            payload_len = LEN_W'($urandom);
            ipg_len     = 8'($urandom);
            mode        = 2'($urandom);
            fixed_byte  = 8'($urandom);
            err_en      = 1'($urandom);
            err_pos     = LEN_W'($urandom);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        logic [7:0] s;
        s = 8'hFF;
        for (int i = 0; i < 2048; i++) begin
            prbs_ref[i] = s;
            s = {s[6:0], ^(s & 8'hB8)};
        end

        repeat (3) @(negedge clk);
        chk("reset_state", obs(), 32'h0);
        mr_main_reset = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", obs(), 32'h0);

        run("single_inc",   1, 4,   12, 0, 0,     0, 0,  -1);
        run("ipg_clamp",    3, 2,   3,  0, 0,     0, 0,  -1);
        run("err_fixed",    1, 5,   12, 2, 8'hA5, 1, 2,  -1);
        run("err_past_end", 1, 5,   12, 2, 8'hA5, 1, 9,  -1);
        run("prbs_reseed",  2, 300, 12, 1, 0,     0, 0,  -1);
        run("continuous",   0, 6,   14, 3, 0,     1, 5,  4);
        run("start_stop",   0, 3,   12, 0, 0,     0, 0,  0);
        run("len_zero",     2, 0,   20, 0, 0,     1, 0,  -1);
        run("inc_wrap",     1, 260, 12, 0, 0,     1, 259, -1);
        for (int k = 0; k < 6; k++)
            run($sformatf("rand%0d", k), $urandom_range(1, 3), $urandom_range(0, 20),
                $urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(0, 255),
                $urandom_range(0, 1), $urandom_range(0, 22), -1);

        // asynchronous reset in the middle of a payload
        @(negedge clk);
        frame_count = 16'd1; payload_len = 11'd20; ipg_len = 8'd12; mode = 2'd0;
        err_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid_payload_pre", obs(), expv(11, 1, 20, 12, 0, 0, 0, 0));
        #2 mr_main_reset = 1'b0;
        #1 chk("async_reset", obs(), 32'h0);
        @(negedge clk);
        mr_main_reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("after_reset c%0d", j), obs(), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
